// File: rtl/fifo_pkg.sv
// Shared types for the async-FIFO read-side consumer.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} rd_state_t;
  localparam int OBUF_DEPTH = 2;
endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry registered output buffer; entry 0 is always the oldest word.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [1:0]            occ,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  valid_q, valid_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (clear) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_d = push_data;
          else               ent1_d = push_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push: occupancy unchanged, queue shifts when full.
          if (occ_q == 2'(OBUF_DEPTH)) begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end else begin
            ent0_d = push_data;
          end
        end
        default: ;
      endcase
    end
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign occ        = occ_q;
  assign head_valid = valid_q;
  assign head_data  = ent0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops the FIFO into a valid/ready stream with
// enable, flush/discard control and saturating transfer/drop counters.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  rd_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic       hs;
  logic       push;
  logic       clear;
  logic [1:0] occ;
  logic [1:0] drop_add;
  logic [CNT_WIDTH+1:0] drop_sum;

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk        (rclk),
    .rst        (rrst),
    .push       (push),
    .push_data  (rdata),
    .pop        (hs),
    .clear      (clear),
    .occ        (occ),
    .head_valid (m_valid),
    .head_data  (m_data)
  );

  assign hs    = m_valid && m_ready;
  assign push  = rinc && (state_q == RUN);
  assign clear = flush && (state_q != FLUSH);

  always_comb begin
    rinc = 1'b0;
    case (state_q)
      // A flush pulse stops popping on its own cycle so no word slips past the drop count.
      RUN:     rinc = en && !flush && !rempty && ((occ < 2'(OBUF_DEPTH)) || m_ready);
      FLUSH:   rinc = !rempty;
      default: rinc = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush)   state_d = FLUSH;
        else if (en) state_d = RUN;
      end
      RUN: begin
        if (flush)    state_d = FLUSH;
        else if (!en) state_d = IDLE;
      end
      FLUSH: begin
        if (rempty) state_d = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A word handed off on the flush entry edge is counted as transferred, not dropped.
  always_comb begin
    drop_add = 2'd0;
    if (clear)                 drop_add = occ - {1'b0, hs};
    else if (state_q == FLUSH) drop_add = {1'b0, rinc};
    drop_sum = {2'b00, drop_q} + {{CNT_WIDTH{1'b0}}, drop_add};
    drop_d   = (drop_sum > {2'b00, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}}
                                                      : drop_sum[CNT_WIDTH-1:0];
    xfer_d = xfer_q;
    if (hs && (xfer_q != {CNT_WIDTH{1'b1}})) xfer_d = xfer_q + 1'b1;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= IDLE;
      xfer_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      drop_q  <= drop_d;
    end
  end

  assign busy     = ((state_q == RUN) && (occ != 2'd0)) || (state_q == FLUSH);
  assign xfer_cnt = xfer_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-based FIFO model.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rempty = 1'b1;
  logic          rinc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] xfer_cnt;
  logic [CW-1:0] drop_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int rinc_cnt = 0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] load_q [$];
  logic [DW-1:0] rx_q [$];

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .en       (en),
    .flush    (flush),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 rclk = ~rclk;

  // FIFO model: pop on rinc, absorb new loads, registered empty/head.
  always @(posedge rclk) begin
    if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    while (load_q.size() > 0) fifo_q.push_back(load_q.pop_front());
    rempty <= (fifo_q.size() == 0);
    rdata  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  always @(negedge rclk) begin
    if (!rrst) begin
      if (rinc) rinc_cnt++;
      if (m_valid && m_ready) rx_q.push_back(m_data);
    end
  end

  a_rinc_safe: assert property (@(posedge rclk) disable iff (rrst) rinc |-> !rempty)
    else $error("rinc asserted while rempty");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic check_rx(input string tag, input logic [DW-1:0] base, input int n);
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), rx_q[i], base + DW'(i));
  endtask

  initial begin
    bit seen;
    // Test 1: reset values, then basic streaming of 0x11,0x22,0x33
    load_q.push_back(8'h11); load_q.push_back(8'h22); load_q.push_back(8'h33);
    @(negedge rclk);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_rinc", rinc, 0);
    check("rst_busy", busy, 0);
    check("rst_xfer", xfer_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    tick();
    rrst = 1'b0; en = 1'b1; m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge rclk);
      seen = rinc;
    end
    check("t1_rinc_seen", seen, 1);
    @(negedge rclk);
    check("t1_v0", m_valid, 1); check("t1_d0", m_data, 8'h11); check("t1_rinc1", rinc, 1);
    @(negedge rclk);
    check("t1_d1", m_data, 8'h22); check("t1_rinc2", rinc, 1);
    @(negedge rclk);
    check("t1_d2", m_data, 8'h33); check("t1_rinc_off", rinc, 0);
    @(negedge rclk);
    check("t1_drained", m_valid, 0);
    check("t1_xfer", xfer_cnt, 3);
    check("t1_rinc_cnt", rinc_cnt, 3);

    // Test 2: backpressure with 5 words
    tick();
    rinc_cnt = 0; rx_q.delete(); m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load_q.push_back(8'hA1 + 8'(i));
    tick(8);
    @(negedge rclk);
    check("t2_pops", rinc_cnt, 2);
    check("t2_valid", m_valid, 1);
    check("t2_head", m_data, 8'hA1);
    check("t2_busy", busy, 1);
    tick(2);
    @(negedge rclk);
    check("t2_head_stable", m_data, 8'hA1);
    tick();
    m_ready = 1'b1;
    tick(10);
    check_rx("t2_rx", 8'hA1, 5);
    check("t2_xfer", xfer_cnt, 8);

    // Test 3: flush with occ=2 and 4 words left in the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load_q.push_back(8'hB1 + 8'(i));
    tick(8);
    @(negedge rclk);
    check("t3_pre_head", m_data, 8'hB1);
    tick();
    rinc_cnt = 0; rx_q.delete(); flush = 1'b1;
    tick();
    flush = 1'b0; m_ready = 1'b1;
    @(negedge rclk);
    check("t3_valid_clr", m_valid, 0);
    check("t3_busy", busy, 1);
    tick(8);
    @(negedge rclk);
    check("t3_flush_pops", rinc_cnt, 4);
    check("t3_drop", drop_cnt, 6);
    check("t3_no_leak", rx_q.size(), 0);
    check("t3_idle_busy", busy, 0);
    check("t3_xfer", xfer_cnt, 8);

    // Test 4: en dropped mid-stream, then resumed
    tick();
    rinc_cnt = 0; rx_q.delete();
    for (int i = 0; i < 6; i++) load_q.push_back(8'h40 + 8'(i));
    tick(2);
    en = 1'b0;
    @(negedge rclk);
    check("t4_rinc_off", rinc, 0);
    check("t4_valid", m_valid, 1);
    check("t4_head", m_data, 8'h40);
    tick(3);
    check("t4_paused_pops", rinc_cnt, 1);
    check("t4_paused_rx", rx_q.size(), 1);
    en = 1'b1;
    tick(10);
    check_rx("t4_rx", 8'h40, 6);
    check("t4_xfer", xfer_cnt, 14);

    // Test 5: asynchronous reset mid-stream with occ=1
    m_ready = 1'b0;
    load_q.push_back(8'h50);
    tick(4);
    @(negedge rclk);
    check("t5_pre_valid", m_valid, 1);
    check("t5_pre_head", m_data, 8'h50);
    tick();
    load_q.push_back(8'h51); load_q.push_back(8'h52);
    #2 rrst = 1'b1;
    #1;
    check("t5_async_valid", m_valid, 0);
    check("t5_async_data", m_data, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_xfer", xfer_cnt, 0);
    check("t5_async_drop", drop_cnt, 0);
    check("t5_async_rinc", rinc, 0);
    tick();
    rrst = 1'b0; m_ready = 1'b1; rx_q.delete();
    tick(8);
    check_rx("t5_rx", 8'h51, 2);
    check("t5_xfer", xfer_cnt, 2);

    // Test 6: xfer_cnt saturation at 15
    rx_q.delete();
    for (int i = 0; i < 20; i++) load_q.push_back(8'h60 + 8'(i));
    tick(30);
    check("t6_rx_count", rx_q.size(), 20);
    if (rx_q.size() == 20) check("t6_last", rx_q[19], 8'h73);
    check("t6_xfer_sat", xfer_cnt, 15);
    check("t6_drop", drop_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO. Lives entirely in the read clock domain and drives the FIFO's rinc from its rdata/rempty.
- Presents the FIFO contents as a valid/ready stream through a 2-entry registered output buffer.
- Adds enable, flush/discard control and delivered/dropped word counters for the read-side datapath.

Parameters:
DATA_WIDTH, 8, width of FIFO words and m_data
CNT_WIDTH, 16, width of the xfer_cnt and drop_cnt statistics counters

Ports:
rclk  input  1  read-domain clock; all logic on the rising edge
rrst  input  1  reset, asynchronous assert, active-high; synchronous deassert handled externally
en  input  1  level; 1 allows streaming from the FIFO
flush  input  1  single-cycle pulse; discard buffered and FIFO-resident data
rdata  input  DATA_WIDTH  FIFO head word, first-word fall-through, valid whenever rempty=0
rempty  input  1  FIFO empty flag, registered in the rclk domain
rinc  output  1  FIFO pop; head word is consumed at the rclk edge where rinc=1
m_data  output  DATA_WIDTH  stream data (head of the output buffer)
m_valid  output  1  stream valid
m_ready  input  1  stream ready from the downstream sink
busy  output  1  1 in RUN with occ>0, and throughout FLUSH
xfer_cnt  output  CNT_WIDTH  words accepted downstream (m_valid&&m_ready), saturating
drop_cnt  output  CNT_WIDTH  words discarded by flush, saturating

Behaviour:
- Reset (rrst=1, asynchronous): state=IDLE, occ=0, m_valid=0, m_data=0, rinc=0, busy=0, xfer_cnt=0, drop_cnt=0. Reset mid-transfer loses buffered words silently.
- Output buffer: 2 entries, occupancy occ in 0..2.
  - m_valid = (occ!=0); m_data = oldest entry. Both come from registers.
  - Each cycle: occ_next = occ + push - pop, where push = rinc in RUN and pop = m_valid&&m_ready.
- States:
  - IDLE: rinc=0; the buffer still drains to downstream. Go to RUN when en=1.
  - RUN: rinc = !rempty && (occ<2 || m_ready). This has a combinational path from m_ready and rempty.
    - Popped rdata is written into the buffer at the same edge.
    - Latency is 1 cycle: FIFO head to m_valid.
    - At occ=2 with m_ready=1, the pop and push share one edge and occ stays 2.
    - Go to IDLE when en=0; rinc=0 from that same cycle.
  - FLUSH: entered from IDLE or RUN on a flush pulse.
    - At the entry edge, occ is cleared. m_valid=0 from the next cycle.
    - Buffered words are added to drop_cnt: occ, or occ-1 if the same-edge m_valid&&m_ready handshake counted in xfer_cnt.
    - In FLUSH: rinc = !rempty, data is discarded, drop_cnt += rinc each cycle.
    - Exit when rempty=1 and rinc=0: go to RUN if en=1, else IDLE.
    - A flush pulse while already in FLUSH is ignored.
- rinc is never 1 while rempty=1. Bench assertion: rinc |-> !rempty.
- Counters:
  - xfer_cnt increments once per handshake.
  - Both counters saturate at 2^CNT_WIDTH-1 with no wrap.
  - Counters are cleared only by rrst.
- Simultaneous en=0 and flush=1: flush wins and the block goes to FLUSH.
- m_valid, once high, holds with m_data stable until m_ready=1, except when cleared at flush entry.

Decomposition:
- Shared package fifo_pkg: typedef enum logic [1:0] {IDLE, RUN, FLUSH} rd_state_t; localparam OBUF_DEPTH=2.
- Sub-module skid_buf2 (DATA_WIDTH): 2-entry registered buffer.
  - Inputs: push, push_data, pop, clear.
  - Outputs: occ[1:0], head_valid, head_data.
- Top holds the FSM, rinc logic and counters.

Test Plan:
- Reset then en=1, m_ready=1, FIFO preloaded 0x11,0x22,0x33 -> rinc high for 3 cycles; m_data 0x11,0x22,0x33 on consecutive cycles, first one cycle after the first rinc; xfer_cnt=3; rinc=0 once rempty=1.
- Backpressure: m_ready=0 with FIFO holding 5 words -> exactly 2 pops, occ=2, m_data=first word held stable. m_ready=1 -> one word per cycle, no loss or duplication, order preserved.
- Flush with occ=2 and 4 words in the FIFO, m_ready=0 -> m_valid=0 the next cycle, 4 rinc pulses, drop_cnt=6, state returns to RUN (en=1). No dropped word ever appears on m_data.
- en toggled 1->0 mid-stream -> rinc=0 in that same cycle; buffered words still delivered; en=1 resumes with no gap in sequence values.
- rrst asserted mid-stream with occ=1 -> all outputs zero immediately, without waiting for rclk. After release with en=1, the next word comes from the FIFO head.
- Saturation with CNT_WIDTH=4: 20 words transferred -> xfer_cnt stops at 15. rinc |-> !rempty assertion holds for all tests.
